// File: rtl/fifo_sched_pkg.sv
// Shared definitions for the two-channel FIFO burst scheduler:
// FSM state encoding, default widths and channel identifiers.
package fifo_sched_pkg;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int TW = 10;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2,
    GAP  = 2'd3
  } state_e;

endpackage

// File: rtl/fifo_sched_outpipe.sv
// Two-stage output pipeline. Stage 1 aligns the read strobe and burst tags
// with the FIFO's one-cycle read latency; stage 2 selects the source FIFO
// data and registers it together with its tags.
module fifo_sched_outpipe #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_in,
  input  logic          ch_in,
  input  logic          first_in,
  input  logic          last_in,
  input  logic [DW-1:0] q0,
  input  logic [DW-1:0] q1,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  output logic          dout_ch,
  output logic          dout_sop,
  output logic          dout_eop
);
  import fifo_sched_pkg::*;

  logic          rd_d1_q, rd_d1_d;
  logic          ch_d1_q, ch_d1_d;
  logic          first_d1_q, first_d1_d;
  logic          last_d1_q, last_d1_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          vld_q, vld_d;
  logic          ch_q, ch_d;
  logic          sop_q, sop_d;
  logic          eop_q, eop_d;

  // Next values for both stages; stage 2 drives zeros whenever no read is in flight.
  always_comb begin
    rd_d1_d    = rd_in;
    ch_d1_d    = ch_in;
    first_d1_d = rd_in & first_in;
    last_d1_d  = rd_in & last_in;
    vld_d      = rd_d1_q;
    dout_d     = '0;
    ch_d       = 1'b0;
    sop_d      = 1'b0;
    eop_d      = 1'b0;
    if (rd_d1_q) begin
      dout_d = (ch_d1_q == CH1) ? q1 : q0;
      ch_d   = ch_d1_q;
      sop_d  = first_d1_q;
      eop_d  = last_d1_q;
    end
  end

  // Pipeline registers, cleared immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_d1_q    <= 1'b0;
      ch_d1_q    <= 1'b0;
      first_d1_q <= 1'b0;
      last_d1_q  <= 1'b0;
      dout_q     <= '0;
      vld_q      <= 1'b0;
      ch_q       <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
    end else begin
      rd_d1_q    <= rd_d1_d;
      ch_d1_q    <= ch_d1_d;
      first_d1_q <= first_d1_d;
      last_d1_q  <= last_d1_d;
      dout_q     <= dout_d;
      vld_q      <= vld_d;
      ch_q       <= ch_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = vld_q;
  assign dout_ch  = ch_q;
  assign dout_sop = sop_q;
  assign dout_eop = eop_q;

endmodule

// File: rtl/fifo_burst_sched.sv
// Two-channel burst scheduler: grants a channel once its FIFO fill level
// reaches the configured threshold, reads exactly threshold words, and
// arbitrates round-robin with an idle gap between bursts.
module fifo_burst_sched #(
  parameter int DW      = fifo_sched_pkg::DW,
  parameter int AW      = fifo_sched_pkg::AW,
  parameter int TW      = fifo_sched_pkg::TW,
  parameter int GAP_CYC = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [TW-1:0] cfg_thd0,
  input  logic [TW-1:0] cfg_thd1,
  input  logic [AW-1:0] usedw0,
  input  logic          empty0,
  input  logic [DW-1:0] q0,
  input  logic [AW-1:0] usedw1,
  input  logic          empty1,
  input  logic [DW-1:0] q1,
  output logic          rdreq0,
  output logic          rdreq1,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  output logic          dout_ch,
  output logic          dout_sop,
  output logic          dout_eop
);
  import fifo_sched_pkg::*;

  localparam int GW = $clog2(GAP_CYC + 2);

  state_e        state_q, state_d;
  logic [TW-1:0] len_q, len_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          last_ch_q, last_ch_d;
  logic          served_q, served_d;

  logic          elig0, elig1;
  logic          rd0, rd1, rd_any, rd_ch;
  logic          at_last, burst_done;
  logic          pick;

  // Eligibility, read strobes and end-of-burst detection for the current state.
  always_comb begin
    elig0      = (cfg_thd0 != '0) && (TW'(usedw0) >= cfg_thd0) && !empty0;
    elig1      = (cfg_thd1 != '0) && (TW'(usedw1) >= cfg_thd1) && !empty1;
    rd0        = (state_q == RD0) && !empty0;
    rd1        = (state_q == RD1) && !empty1;
    rd_any     = rd0 | rd1;
    rd_ch      = (state_q == RD1) ? CH1 : CH0;
    at_last    = (cnt_q == (len_q - TW'(1)));
    burst_done = rd_any && at_last;
  end

  // Next-state logic: arbitration in IDLE, read counting in RDx, gap timing in GAP.
  // Until a burst has been served since reset, contention goes to ch0.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    last_ch_d = last_ch_q;
    served_d  = served_q;
    pick      = CH0;
    case (state_q)
      IDLE: begin
        if (elig0 || elig1) begin
          if (elig0 && elig1) begin
            pick = (served_q && (last_ch_q == CH0)) ? CH1 : CH0;
          end else begin
            pick = elig1 ? CH1 : CH0;
          end
          state_d = (pick == CH1) ? RD1 : RD0;
          len_d   = (pick == CH1) ? cfg_thd1 : cfg_thd0;
          cnt_d   = '0;
        end
      end
      RD0, RD1: begin
        if (rd_any) begin
          cnt_d = cnt_q + TW'(1);
        end
        if (burst_done) begin
          last_ch_d = rd_ch;
          served_d  = 1'b1;
          gap_d     = '0;
          state_d   = (GAP_CYC > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYC - 1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scheduler state register; reset discards any partially read burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      last_ch_q <= CH0;
      served_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      last_ch_q <= last_ch_d;
      served_q  <= served_d;
    end
  end

  assign rdreq0 = rd0;
  assign rdreq1 = rd1;

  fifo_sched_outpipe #(.DW(DW)) u_outpipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_in    (rd_any),
    .ch_in    (rd_ch),
    .first_in (cnt_q == '0),
    .last_in  (at_last),
    .q0       (q0),
    .q1       (q1),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_ch  (dout_ch),
    .dout_sop (dout_sop),
    .dout_eop (dout_eop)
  );

endmodule

// File: tb/tb_fifo_burst_sched.sv
// Directed testbench for fifo_burst_sched with behavioural FIFO models
// and a negedge monitor that logs every read strobe and output word.
module tb_fifo_burst_sched;

  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int TW  = 10;
  localparam int GAP = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [TW-1:0] cfg_thd0 = '0;
  logic [TW-1:0] cfg_thd1 = '0;
  logic [AW-1:0] usedw0, usedw1;
  logic          empty0, empty1;
  logic [DW-1:0] q0 = '0;
  logic [DW-1:0] q1 = '0;
  logic          rdreq0, rdreq1;
  logic [DW-1:0] dout;
  logic          dout_vld, dout_ch, dout_sop, dout_eop;

  int n_vec = 0;
  int n_err = 0;

  fifo_burst_sched #(.DW(DW), .AW(AW), .TW(TW), .GAP_CYC(GAP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_thd0 (cfg_thd0),
    .cfg_thd1 (cfg_thd1),
    .usedw0   (usedw0),
    .empty0   (empty0),
    .q0       (q0),
    .usedw1   (usedw1),
    .empty1   (empty1),
    .q1       (q1),
    .rdreq0   (rdreq0),
    .rdreq1   (rdreq1),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_ch  (dout_ch),
    .dout_sop (dout_sop),
    .dout_eop (dout_eop)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Behavioural normal-mode FIFOs: write side driven by the stimulus,
  // read side pops on rdreq with data valid the following cycle.
  logic [7:0] mem0 [4096];
  logic [7:0] mem1 [4096];
  int  wp0 = 0, wp1 = 0, rp0 = 0, rp1 = 0;
  logic fifo_clr = 1'b0;
  logic force_empty1 = 1'b0;

  assign usedw0 = ((wp0 - rp0) > 255) ? 8'd255 : 8'(wp0 - rp0);
  assign usedw1 = ((wp1 - rp1) > 255) ? 8'd255 : 8'(wp1 - rp1);
  assign empty0 = (wp0 == rp0);
  assign empty1 = (wp1 == rp1) || force_empty1;

  // FIFO read side
  always @(posedge clk) begin
    if (fifo_clr) begin
      rp0 <= wp0;
      rp1 <= wp1;
    end else begin
      if (rdreq0 && (wp0 != rp0)) begin
        q0  <= mem0[rp0];
        rp0 <= rp0 + 1;
      end
      if (rdreq1 && (wp1 != rp1)) begin
        q1  <= mem1[rp1];
        rp1 <= rp1 + 1;
      end
    end
  end

  // Monitor log, sampled on the falling edge
  int   cyc = 0, rd_n = 0, out_n = 0, both_hi = 0;
  int   rd_cyc  [1024];
  logic rd_chl  [1024];
  int   out_cyc [1024];
  logic [7:0] out_dat [1024];
  logic out_chl [1024];
  logic out_sopl[1024];
  logic out_eopl[1024];

  always @(negedge clk) begin
    if (rdreq0 && rdreq1) both_hi++;
    if ((rdreq0 || rdreq1) && rd_n < 1024) begin
      rd_cyc[rd_n] = cyc;
      rd_chl[rd_n] = rdreq1;
      rd_n++;
    end
    if (dout_vld && out_n < 1024) begin
      out_cyc[out_n]  = cyc;
      out_dat[out_n]  = dout;
      out_chl[out_n]  = dout_ch;
      out_sopl[out_n] = dout_sop;
      out_eopl[out_n] = dout_eop;
      out_n++;
    end
    cyc++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pushWords(input bit ch, input int n, input int base);
    for (int k = 0; k < n; k++) begin
      if (ch) begin
        mem1[wp1] = 8'((base + k) % 256);
        wp1++;
      end else begin
        mem0[wp0] = 8'((base + k) % 256);
        wp0++;
      end
    end
  endtask

  task automatic applyStimulus(input int t0, input int t1);
    cfg_thd0 = TW'(t0);
    cfg_thd1 = TW'(t1);
  endtask

  task automatic clearFifos();
    fifo_clr = 1'b1;
    tick(1);
    fifo_clr = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Check one logged burst word by word; stall_k marks the word allowed to
  // follow a read gap.
  task automatic checkBurst(input string tag, input int ri, input int oi,
                            input bit ch, input int len, input int base,
                            input int stall_k);
    for (int k = 0; k < len; k++) begin
      checkOutput($sformatf("%s w%0d rdch", tag, k), int'(rd_chl[ri+k]), int'(ch));
      if (k > 0 && k != stall_k)
        checkOutput($sformatf("%s w%0d rdseq", tag, k), rd_cyc[ri+k] - rd_cyc[ri+k-1], 1);
      checkOutput($sformatf("%s w%0d lat", tag, k), out_cyc[oi+k] - rd_cyc[ri+k], 2);
      checkOutput($sformatf("%s w%0d data", tag, k), int'(out_dat[oi+k]), (base + k) % 256);
      checkOutput($sformatf("%s w%0d ch", tag, k), int'(out_chl[oi+k]), int'(ch));
      checkOutput($sformatf("%s w%0d sop", tag, k), int'(out_sopl[oi+k]), (k == 0) ? 1 : 0);
      checkOutput($sformatf("%s w%0d eop", tag, k), int'(out_eopl[oi+k]), (k == len - 1) ? 1 : 0);
    end
  endtask

  initial begin
    int r, o;

    // Reset values
    tick(3);
    checkOutput("rst rdreq0", int'(rdreq0), 0);
    checkOutput("rst rdreq1", int'(rdreq1), 0);
    checkOutput("rst dout_vld", int'(dout_vld), 0);
    checkOutput("rst dout", int'(dout), 0);
    checkOutput("rst dout_ch", int'(dout_ch), 0);
    checkOutput("rst dout_sop", int'(dout_sop), 0);
    checkOutput("rst dout_eop", int'(dout_eop), 0);
    rst_n = 1'b1;
    tick(2);

    // ch0 alone, fill ramps 1..5 against threshold 4
    $display("[TB] ch0 single burst");
    r = rd_n; o = out_n;
    applyStimulus(4, 0);
    for (int i = 0; i < 5; i++) begin
      pushWords(1'b0, 1, 'h10 + i);
      tick(1);
    end
    tick(20);
    checkOutput("s1 reads", rd_n - r, 4);
    checkOutput("s1 words", out_n - o, 4);
    checkBurst("s1", r, o, 1'b0, 4, 'h10, -1);

    // Both channels eligible from reset: ch0,ch1,ch0,ch1 with gaps
    $display("[TB] round robin");
    rst_n = 1'b0;
    applyStimulus(0, 0);
    tick(1);
    rst_n = 1'b1;
    clearFifos();
    pushWords(1'b0, 40, 'h20);
    pushWords(1'b1, 40, 'h60);
    r = rd_n; o = out_n;
    applyStimulus(3, 2);
    tick(30);
    applyStimulus(0, 0);
    tick(15);
    checkBurst("s2b0", r,     o,     1'b0, 3, 'h20, -1);
    checkBurst("s2b1", r + 3, o + 3, 1'b1, 2, 'h60, -1);
    checkBurst("s2b2", r + 5, o + 5, 1'b0, 3, 'h23, -1);
    checkBurst("s2b3", r + 8, o + 8, 1'b1, 2, 'h62, -1);
    checkOutput("s2 gap01", rd_cyc[r+3] - rd_cyc[r+2], GAP + 2);
    checkOutput("s2 gap12", rd_cyc[r+5] - rd_cyc[r+4], GAP + 2);
    checkOutput("s2 gap23", rd_cyc[r+8] - rd_cyc[r+7], GAP + 2);
    clearFifos();

    // Disabled channel and unreachable threshold
    $display("[TB] disable and oversize threshold");
    pushWords(1'b0, 200, 0);
    pushWords(1'b1, 250, 0);
    r = rd_n;
    applyStimulus(0, 300);
    tick(30);
    checkOutput("s3 no reads", rd_n - r, 0);
    applyStimulus(0, 0);
    clearFifos();

    // Empty stall after the second read of a 4-word ch1 burst
    $display("[TB] empty stall");
    pushWords(1'b1, 4, 'hA0);
    r = rd_n; o = out_n;
    applyStimulus(0, 4);
    tick(3);
    force_empty1 = 1'b1;
    tick(2);
    force_empty1 = 1'b0;
    tick(20);
    checkOutput("s4 reads", rd_n - r, 4);
    checkOutput("s4 words", out_n - o, 4);
    checkOutput("s4 stall gap", rd_cyc[r+2] - rd_cyc[r+1], 3);
    checkBurst("s4", r, o, 1'b1, 4, 'hA0, 2);
    applyStimulus(0, 0);
    clearFifos();

    // Threshold changed 8->2 during the third read
    $display("[TB] config change mid-burst");
    pushWords(1'b0, 10, 'h40);
    r = rd_n; o = out_n;
    applyStimulus(8, 0);
    tick(3);
    applyStimulus(2, 0);
    tick(30);
    checkOutput("s5 reads", rd_n - r, 10);
    checkBurst("s5b0", r,     o,     1'b0, 8, 'h40, -1);
    checkBurst("s5b1", r + 8, o + 8, 1'b0, 2, 'h48, -1);
    checkOutput("s5 gap", rd_cyc[r+8] - rd_cyc[r+7], GAP + 2);
    applyStimulus(0, 0);
    clearFifos();

    // Reset during the third read of a 6-word burst
    $display("[TB] reset mid-burst");
    pushWords(1'b0, 12, 'h70);
    r = rd_n;
    applyStimulus(6, 0);
    tick(3);
    rst_n = 1'b0;
    tick(1);
    checkOutput("s6 rst rdreq0", int'(rdreq0), 0);
    checkOutput("s6 rst rdreq1", int'(rdreq1), 0);
    checkOutput("s6 rst dout_vld", int'(dout_vld), 0);
    checkOutput("s6 rst dout", int'(dout), 0);
    checkOutput("s6 rst dout_ch", int'(dout_ch), 0);
    checkOutput("s6 rst dout_sop", int'(dout_sop), 0);
    checkOutput("s6 rst dout_eop", int'(dout_eop), 0);
    checkOutput("s6 aborted reads", rd_n - r, 2);
    r = rd_n; o = out_n;
    rst_n = 1'b1;
    tick(30);
    checkOutput("s6 reads", rd_n - r, 6);
    checkBurst("s6", r, o, 1'b0, 6, 'h72, -1);

    checkOutput("rdreq overlap", both_hi, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
